// File: rtl/fp_mul_sched_pkg.sv
// Shared fragment-stage FP definitions used by the multiplier scheduler:
// field positions of the 24-bit word, the in-flight tag type and the default latency.
package fp_mul_sched_pkg;

  localparam int FP_WIDTH           = 24;
  localparam int FP_SIGN_BIT        = 23;
  localparam int FP_EXP_MSB         = 22;
  localparam int FP_EXP_LSB         = 15;
  localparam int FP_MANT_MSB        = 14;
  localparam int FP_MUL_LATENCY_DEF = 2;

  // Wide enough for the largest supported requester count (8).
  localparam int FP_ID_W = 3;

  typedef struct packed {
    logic               valid;
    logic [FP_ID_W-1:0] id;
  } fp_tag_t;

endpackage

// File: rtl/fp_mul_rr_arb.sv
// Round-robin arbiter: picks the first eligible requester at or after rr_ptr_i.
// With FP_MUL_SCHED_PRIO_EN defined, requester 0 wins whenever it is eligible.
module fp_mul_rr_arb #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] elig_i,
  input  logic [PTR_W-1:0]   rr_ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [PTR_W-1:0]   grant_idx_o,
  output logic               grant_any_o
);

  always_comb begin
    int j;
    j           = 0;
    grant_o     = '0;
    grant_idx_o = '0;
    grant_any_o = 1'b0;
`ifdef FP_MUL_SCHED_PRIO_EN
    if (elig_i[0]) begin
      grant_o[0]  = 1'b1;
      grant_any_o = 1'b1;
    end
`endif
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(rr_ptr_i) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!grant_any_o && elig_i[j]) begin
        grant_o[j]  = 1'b1;
        grant_idx_o = PTR_W'(j);
        grant_any_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fp_mul_sched.sv
// Shares one pipelined FP multiplier among NUM_REQ requesters, tracking owner IDs
// through the fixed multiplier latency. Build option: FP_MUL_SCHED_PRIO_EN.
import fp_mul_sched_pkg::*;

module fp_mul_sched #(
  parameter int NUM_REQ     = 4,
  parameter int WIDTH       = FP_WIDTH,
  parameter int MUL_LATENCY = FP_MUL_LATENCY_DEF,
  parameter int MAX_OUT     = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid_i,
  output logic [NUM_REQ-1:0]       req_ready_o,
  input  logic [NUM_REQ*WIDTH-1:0] req_a_i,
  input  logic [NUM_REQ*WIDTH-1:0] req_b_i,
  output logic                     issue_valid_o,
  output logic [WIDTH-1:0]         issue_a_o,
  output logic [WIDTH-1:0]         issue_b_o,
  input  logic [WIDTH-1:0]         result_i,
  output logic [NUM_REQ-1:0]       res_valid_o,
  output logic [WIDTH-1:0]         res_data_o
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_OUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUT);

  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]   out_cnt_q [NUM_REQ];
  logic [CNT_W-1:0]   out_cnt_d [NUM_REQ];
  logic [NUM_REQ-1:0] elig, grant, ret_onehot, res_valid_q;
  logic [PTR_W-1:0]   grant_idx;
  logic               grant_any;
  logic               issue_valid_q;
  logic [FP_ID_W-1:0] issue_id_q;
  logic [WIDTH-1:0]   issue_a_q, issue_b_q, issue_a_d, issue_b_d;
  logic [WIDTH-1:0]   res_data_q;
  fp_tag_t            tag_q [MUL_LATENCY];
  fp_tag_t            tail;

  always_comb begin
    elig = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      elig[i] = req_valid_i[i] && (out_cnt_q[i] < CNT_MAX);
    end
  end

  fp_mul_rr_arb #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_arb (
    .elig_i      (elig),
    .rr_ptr_i    (rr_ptr_q),
    .grant_o     (grant),
    .grant_idx_o (grant_idx),
    .grant_any_o (grant_any)
  );

  assign req_ready_o = rst ? '0 : grant;

  // The tail of the tag pipe lines up with result_i for the same operation.
  assign tail = tag_q[MUL_LATENCY-1];

  always_comb begin
    ret_onehot = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      ret_onehot[i] = tail.valid && (tail.id == FP_ID_W'(i));
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      out_cnt_d[i] = out_cnt_q[i];
      if (grant[i] && !ret_onehot[i]) begin
        out_cnt_d[i] = out_cnt_q[i] + CNT_W'(1);
      end else if (!grant[i] && ret_onehot[i]) begin
        out_cnt_d[i] = out_cnt_q[i] - CNT_W'(1);
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (grant_any) begin
      if (grant_idx == PTR_W'(NUM_REQ - 1)) begin
        rr_ptr_d = '0;
      end else begin
        rr_ptr_d = grant_idx + PTR_W'(1);
      end
`ifdef FP_MUL_SCHED_PRIO_EN
      if (grant[0]) rr_ptr_d = rr_ptr_q;
`endif
    end
  end

  always_comb begin
    issue_a_d = issue_a_q;
    issue_b_d = issue_b_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        issue_a_d = req_a_i[i*WIDTH +: WIDTH];
        issue_b_d = req_b_i[i*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q      <= '0;
      issue_valid_q <= 1'b0;
      issue_id_q    <= '0;
      issue_a_q     <= '0;
      issue_b_q     <= '0;
      res_valid_q   <= '0;
      res_data_q    <= '0;
      for (int i = 0; i < NUM_REQ; i++) out_cnt_q[i] <= '0;
      for (int s = 0; s < MUL_LATENCY; s++) tag_q[s] <= '0;
    end else begin
      rr_ptr_q      <= rr_ptr_d;
      issue_valid_q <= grant_any;
      if (grant_any) issue_id_q <= FP_ID_W'(grant_idx);
      issue_a_q     <= issue_a_d;
      issue_b_q     <= issue_b_d;
      res_valid_q   <= ret_onehot;
      if (tail.valid) res_data_q <= result_i;
      for (int i = 0; i < NUM_REQ; i++) out_cnt_q[i] <= out_cnt_d[i];
      tag_q[0] <= '{valid: issue_valid_q, id: issue_id_q};
      for (int s = 1; s < MUL_LATENCY; s++) tag_q[s] <= tag_q[s-1];
    end
  end

  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        assert (!(grant[i] && !ret_onehot[i] && out_cnt_q[i] == CNT_MAX));
        assert (!(ret_onehot[i] && !grant[i] && out_cnt_q[i] == '0));
      end
    end
  end

  assign issue_valid_o = issue_valid_q;
  assign issue_a_o     = issue_a_q;
  assign issue_b_o     = issue_b_q;
  assign res_valid_o   = res_valid_q;
  assign res_data_o    = res_data_q;

endmodule
